display_scanner: RTL and testbench
==================================

Name: display_scanner

Overview:
- Time-multiplexed scan controller for the board's common-anode seven-segment bank.
- Sequences one shared per-digit decoder, SevenSegmentDisplay, across NUM_DIGITS digits.
- Each cycle it drives the current digit's 4-bit code onto the decoder input and asserts that digit's active-low anode.
- Includes a tear-free frame-synchronous value update, inter-digit ghost blanking, per-digit enable and leading-zero suppression.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; range 2..16.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off (anti-ghosting); must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- value_in  in  4*NUM_DIGITS  digit codes; nibble i = digit i; digit 0 is least significant/rightmost
- load  in  1  one-cycle strobe; captures value_in into the pending register
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit kept dark
- blank_lz  in  1  1 = suppress leading zeros
- display_out  out  4  code for the current digit; feeds the decoder's display_out input
- an  out  NUM_DIGITS  active-low anodes; at most one bit low
- digit_idx  out  clog2(NUM_DIGITS)  digit slot currently scanned
- frame_tick  out  1  one-cycle pulse at each frame wrap
- update_ack  out  1  one-cycle pulse when pending is committed to active

Behaviour:
- Timing and registers
  - All outputs are registered.
  - Reset values: an all 1s, display_out 0, digit_idx 0, frame_tick 0, update_ack 0.
  - Internal reset values: active register 0, pending register 0, pending_valid 0, state BLANK, slot counter 0.
  - Reset mid-operation aborts the slot immediately and discards any pending value.
- States and transitions
  - Two states: BLANK and ON. Slot counter runs 0..REFRESH_DIV-1 and wraps to 0 at the end of each slot.
  - BLANK: counter 0..BLANK_CYCLES-1; an all 1s.
  - At counter == BLANK_CYCLES-1, transition to ON.
  - ON: counter BLANK_CYCLES..REFRESH_DIV-1; an[digit_idx] = 0 unless the digit is dark; display_out = active nibble[digit_idx].
  - At counter == REFRESH_DIV-1, transition to BLANK. digit_idx increments, wrapping NUM_DIGITS-1 → 0.
- Output timing
  - Outputs reflect the state in the same cycle the state is entered (registered next-state decode).
  - After reset deasserts, digit 0 turns on at cycle BLANK_CYCLES.
- Dark digits
  - A digit is dark if digit_en[i] = 0 or it is leading-zero suppressed.
  - Dark slots still consume REFRESH_DIV cycles, so frame period is fixed at NUM_DIGITS*REFRESH_DIV.
  - display_out still shows the nibble during a dark slot; an stays all 1s.
- Leading-zero suppression
  - Applies when blank_lz = 1.
  - Digit i (i ≥ 1) is suppressed iff active nibbles NUM_DIGITS-1 down to i are all 4'h0.
  - Digit 0 is never suppressed.
  - Evaluated on the active register only.
- Update handshake
  - load = 1 sets pending ← value_in and pending_valid ← 1.
  - A load while pending_valid = 1 overwrites pending; the last value wins.
- Frame wrap
  - The wrap is the first cycle of the digit-0 slot following digit NUM_DIGITS-1. It is not asserted for the first slot after reset.
  - On the wrap cycle, frame_tick = 1.
  - If pending_valid was 1 before this cycle: active ← pending, pending_valid ← 0, update_ack = 1.
  - Load on the wrap cycle: the commit uses the prior pending value. The new value becomes pending and commits at the next wrap.
  - If nothing was pending beforehand, a load on the wrap cycle is not committed until the next wrap.
  - The active register never changes mid-frame.
- Width rules
  - Counter width is clog2(REFRESH_DIV).
  - No arithmetic on digit values.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, load value_in=16'h1234 at cycle 3, digit_en=4'hF, blank_lz=0:
  - an=4'hF for cycles 0-1, then 4'hE for cycles 2-7 with display_out=4'h0 (active still 0).
  - First frame_tick/update_ack at cycle 32.
  - From cycle 34, display_out=4'h4 with an=4'hE.
- Scan order after commit: slots show display_out 4,3,2,1 with an E,D,B,7, each low for 6 cycles after 2 blank cycles.
  - frame_tick period is 32 cycles.
- blank_lz=1, active=16'h0050:
  - Digits 3 and 2 are dark (an=4'hF in their slots); digits 1 and 0 are lit.
  - active=16'h0000 lights digit 0 only.
- digit_en=4'b1010: only digits 1 and 3 ever drive anodes low; frame period stays 32 cycles.
- Loads 16'hAAAA then 16'hBBBB mid-frame, and a load of 16'hCCCC on the wrap cycle:
  - The wrap commits 16'hBBBB with update_ack=1.
  - The next wrap commits 16'hCCCC.
- Assert reset during digit 2's ON phase with a load pending:
  - an=4'hF, digit_idx=0, display_out=0 asynchronously.
  - After release, no update_ack occurs at the next wrap.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan controller for a common-anode seven-segment bank.
// Ports: clk, reset (async, active-high); value_in/load capture a pending frame value;
// digit_en and blank_lz select which digits stay dark; display_out, an and digit_idx drive
// the shared decoder and the active-low anodes; frame_tick pulses on every frame wrap and
// update_ack pulses when the pending value is committed to the displayed register.
module display_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       value_in,
   input  logic                          load,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   input  logic                          blank_lz,
   output logic [3:0]                    display_out,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick,
   output logic                          update_ack
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int DW = $clog2(NUM_DIGITS);

   typedef enum logic {BLANK, ON} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d, pending_q, pending_d;
   logic                    pvalid_q, pvalid_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [3:0]              disp_q, disp_d;
   logic                    tick_q, tick_d, ack_q, ack_d;
   logic                    slot_end, wrap, take, dark;
   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   zf;

   always_comb begin
      slot_end  = cnt_q == CW'(REFRESH_DIV - 1);
      wrap      = slot_end && idx_q == DW'(NUM_DIGITS - 1);
      // a load in the cycle just before the wrap is already pending when the wrap commits
      take      = load || pvalid_q;
      cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
      idx_d     = !slot_end ? idx_q : wrap ? '0 : idx_q + 1'b1;
      state_d   = slot_end ? BLANK : cnt_q == CW'(BLANK_CYCLES - 1) ? ON : state_q;
      pending_d = load ? value_in : pending_q;
      pvalid_d  = take && !wrap;
      active_d  = wrap && take ? pending_d : active_q;
      tick_d    = wrap;
      ack_d     = wrap && take;
      // outputs are decoded from next-state values so they line up with the state they describe
      for (int i = 0; i < NUM_DIGITS; i++) nib[i] = active_d[4*i +: 4];
      // zf[i]: nibbles NUM_DIGITS-1 down to i are all zero
      zf[NUM_DIGITS-1] = nib[NUM_DIGITS-1] == 4'h0;
      for (int i = NUM_DIGITS - 2; i >= 0; i--) zf[i] = zf[i+1] && nib[i] == 4'h0;
      dark   = !digit_en[idx_d] || (blank_lz && idx_d != '0 && zf[idx_d]);
      an_d   = state_d == ON && !dark ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      disp_d = nib[idx_d];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         active_q  <= '0;
         pending_q <= '0;
         pvalid_q  <= 1'b0;
         an_q      <= '1;
         disp_q    <= '0;
         tick_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         pvalid_q  <= pvalid_d;
         an_q      <= an_d;
         disp_q    <= disp_d;
         tick_q    <= tick_d;
         ack_q     <= ack_d;
      end
   end

   assign display_out = disp_q;
   assign an          = an_q;
   assign digit_idx   = idx_q;
   assign frame_tick  = tick_q;
   assign update_ack  = ack_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: scoreboard bench for display_scanner with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_display_scanner;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  digit_en = 4'hF;
   logic [3:0]  display_out, an;
   logic [1:0]  digit_idx;
   logic        frame_tick, update_ack;

   int          checks = 0;
   int          failures = 0;
   int          c = 0;
   logic [15:0] m_act = '0, m_pend = '0;
   logic        m_pv = 1'b0;
   logic [3:0]  cur_en = 4'hF;
   logic        cur_lz = 1'b0;
   logic [11:0] sb [$];

   display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .value_in(value_in), .load(load), .digit_en(digit_en),
      .blank_lz(blank_lz), .display_out(display_out), .an(an), .digit_idx(digit_idx),
      .frame_tick(frame_tick), .update_ack(update_ack)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // drive one cycle of stimulus, predict the following cycle's outputs, then compare them
   task automatic step(input logic ld, input logic [15:0] v);
      int n, ph, d;
      logic tick, ack, dk;
      logic [3:0] a;
      load = ld;
      value_in = v;
      digit_en = cur_en;
      blank_lz = cur_lz;
      if (ld) begin
         m_pend = v;
         m_pv = 1'b1;
      end
      n = c + 1;
      ph = n % 8;
      d = (n / 8) % 4;
      tick = 1'b0;
      ack = 1'b0;
      if (ph == 0 && n >= 32 && d == 0) begin
         tick = 1'b1;
         if (m_pv) begin
            m_act = m_pend;
            m_pv = 1'b0;
            ack = 1'b1;
         end
      end
      dk = !cur_en[d] || (cur_lz && d != 0 && (m_act >> (4*d)) == 16'h0);
      a = (ph >= 2 && !dk) ? ~(4'b0001 << d) : 4'hF;
      sb.push_back({a, m_act[4*d +: 4], 2'(d), tick, ack});
      @(posedge clk);
      #1;
      c++;
      load = 1'b0;
      check_eq($sformatf("cyc%0d", c), {20'h0, an, display_out, digit_idx, frame_tick, update_ack},
               {20'h0, sb.pop_front()});
   endtask

   task automatic run_to(input int m);
      do step(1'b0, 16'h0); while (c % 32 != m);
   endtask

   initial begin
      #14;
      check_eq("reset_an", an, 4'hF);
      check_eq("reset_rest", {display_out, digit_idx, frame_tick, update_ack}, 8'h00);
      #2 reset = 1'b0;
      repeat (3) step(1'b0, 16'h0);
      step(1'b1, 16'h1234);
      while (c < 70) step(1'b0, 16'h0);
      cur_lz = 1'b1;
      run_to(9);
      step(1'b1, 16'h0050);
      run_to(0);
      run_to(0);
      run_to(4);
      step(1'b1, 16'h0000);
      run_to(0);
      run_to(0);
      cur_lz = 1'b0;
      cur_en = 4'b1010;
      run_to(0);
      run_to(0);
      cur_en = 4'hF;
      run_to(5);
      step(1'b1, 16'hAAAA);
      run_to(12);
      step(1'b1, 16'hBBBB);
      run_to(0);
      check_eq("wrap_ack_bbbb", update_ack, 1'b1);
      check_eq("wrap_disp_bbbb", display_out, 4'hB);
      step(1'b1, 16'hCCCC);
      run_to(0);
      check_eq("wrap_ack_cccc", update_ack, 1'b1);
      run_to(10);
      step(1'b1, 16'h5555);
      run_to(20);
      #2 reset = 1'b1;
      #1;
      check_eq("async_an", an, 4'hF);
      check_eq("async_idx", digit_idx, 2'd0);
      check_eq("async_disp", display_out, 4'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      c = 0;
      m_act = '0;
      m_pend = '0;
      m_pv = 1'b0;
      while (c < 70) step(1'b0, 16'h0);
      check_eq("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
